// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b sequencer around one full-subtractor cell (optional ovf output via SERIAL_SUB_SIGNED_OVF_EN)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]       state;
  logic [WIDTH-1:0] sa, sb, sr, sr_n;
  logic             brw, cd, cb, last;
  logic [CNT_W-1:0] cnt;
  assign busy = state == RUN;
  // full-subtractor cell on the operand LSBs and the shifted-in result word
  always_comb begin
    cd   = sa[0] ^ sb[0] ^ brw;
    cb   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    sr_n = WIDTH'({cd, sr} >> 1);
    last = cnt == CNT_W'(WIDTH - 1);
  end
  // sequencer: load on accepted start, shift one bit per RUN cycle, publish on the last bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa    <= a;
          sb    <= b;
          brw   <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        sr  <= sr_n;
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        brw <= cb;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          diff  <= sr_n;
          bout  <= cb;
          done  <= 1'b1;
          state <= IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          ovf   <= brw ^ cb;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: scoreboard bench with arithmetic reference model
module tb_serial_subtractor_ctrl;
  localparam int W = 8;
  typedef struct packed {
    int         c;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic busy, done, bout;
  logic start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic busy1, done1, bout1;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic ovf, ovf1;
`endif

  int ntot = 0, npass = 0;
  int cyc = 0, acc = -100, free_edge = 0, clr_cyc = -1;
  exp_t q[$];
  logic [7:0] ld = '0;
  logic lb = 1'b0, lo = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // reference model: an operation accepted at edge e completes W edges later; the unit is free again one edge after that
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      acc = -100;
      free_edge = 0;
      clr_cyc = cyc;
    end else if (start && cyc >= free_edge) begin
      e.c  = cyc + W;
      e.d  = a - b;
      e.bo = a < b;
      e.ov = (a[7] != b[7]) && (e.d[7] != a[7]);
      q.push_back(e);
      acc = cyc;
      free_edge = cyc + W + 1;
    end
  end

  // monitor: pop the expected result when done is due, and check held outputs every cycle
  always @(negedge clk) begin
    exp_t e;
    logic ed;
    if (cyc >= 1) begin
      if (clr_cyc == cyc) begin
        ld = '0; lb = 1'b0; lo = 1'b0;
      end
      ed = q.size() > 0 && q[0].c == cyc;
      chk("done", done, ed);
      if (ed) begin
        e = q.pop_front();
        ld = e.d; lb = e.bo; lo = e.ov;
      end
      chk("busy", busy, cyc >= acc && cyc < acc + W);
      chk("diff", diff, ld);
      chk("bout", bout, lb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      chk("ovf", ovf, lo);
`endif
    end
  end

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] p;
    gap(3);
    rst_n = 1'b1;
    gap(1);
    op(8'h5A, 8'h3C); gap(W + 2);
    op(8'h00, 8'h01); gap(W + 2);
    op(8'h80, 8'h80); gap(W + 4);
    op(8'h10, 8'h01); gap(2);
    op(8'hFF, 8'h00); gap(W + 2);
    op(8'h7F, 8'h01); gap(W - 1);
    op(8'h03, 8'h05); gap(W + 2);
    op(8'h44, 8'h99); gap(3);
    rst_n = 1'b0; gap(1);
    rst_n = 1'b1; gap(W + 2);
    op(8'h22, 8'h11); gap(W + 2);
    op(8'h80, 8'h01); gap(W + 1);
    op(8'h7F, 8'hFF); gap(W + 1);
    op(8'h05, 8'h03); gap(W + 1);
    for (int i = 0; i < 400; i++) begin
      start = $urandom_range(0, 3) == 0;
      a = 8'($urandom); b = 8'($urandom);
      rst_n = $urandom_range(0, 80) != 0;
      gap(1);
    end
    start = 1'b0; rst_n = 1'b1;
    gap(W + 3);
    chk("queue_empty", 64'(q.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      p = 2'(i);
      start1 = 1'b1; a1 = p[1]; b1 = p[0];
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~p[1]; b1 = ~p[0];
      @(negedge clk);
      chk("w1_busy_run", busy1, 1'b1);
      chk("w1_done_early", done1, 1'b0);
      @(negedge clk);
      chk("w1_done", done1, 1'b1);
      chk("w1_busy_end", busy1, 1'b0);
      chk("w1_diff", diff1, 1'(p[1] - p[0]));
      chk("w1_bout", bout1, p[1] < p[0]);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      chk("w1_ovf", ovf1, p[1] < p[0]);
`endif
      @(negedge clk);
      chk("w1_done_pulse", done1, 1'b0);
      chk("w1_hold", diff1, 1'(p[1] - p[0]));
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial subtraction sequencer that drives one full-subtractor cell (a, b, bin -> diff, bout) over a WIDTH-bit operand pair, LSB first, holding the borrow between cycles. It trades WIDTH cycles of latency for a single subtractor cell. Used where area matters more than throughput. A start/busy/done handshake serves one requester.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.
CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
start  input  1  request; accepted only when busy=0.
a  input  WIDTH  minuend; sampled on the accepting edge only.
b  input  WIDTH  subtrahend; sampled on the accepting edge only.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse when diff/bout are updated.
diff  output  WIDTH  registered result a-b modulo 2^WIDTH.
bout  output  1  registered final borrow; 1 iff a<b unsigned.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, diff=0, bout=0, internal shift regs, borrow flop and counter all 0. Reset mid-operation aborts the operation: no done pulse, and diff/bout go to 0.
- States: IDLE, RUN.
- IDLE: if start=1 at an edge, the controller:
  - loads a and b into the operand shift regs;
  - clears the borrow flop and the counter;
  - moves to RUN with busy=1 from the next cycle.
  Otherwise it stays in IDLE.
- RUN, each edge:
  - Cell inputs are the operand LSBs and the borrow flop.
  - Cell diff shifts into the MSB of the result shift reg (right shift).
  - Operand regs shift right by 1.
  - Borrow flop <= cell bout.
  - Counter increments.
- RUN, last bit (counter==WIDTH-1 at the edge):
  - diff <= completed result (the final shifted value);
  - bout <= final cell bout;
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge k -> busy high during cycles k+1..k+WIDTH, done high only in cycle k+WIDTH+1, busy low in that same cycle.
- WIDTH=1: exactly one RUN cycle.
- done is high for exactly one cycle per completed operation. It is never asserted by start alone.
- start while busy=1 is ignored; a/b changes while busy have no effect.
- start=1 in the done cycle (state IDLE) is accepted: back-to-back operations, no idle bubble required.
- diff/bout hold their value from done until the next done or reset. Intermediate shifting never disturbs them.
- Arithmetic: diff = (a - b) mod 2^WIDTH, bout = (a < b), both unsigned. No incoming borrow port; borrow seeds at 0.

Optional Feature:
Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), updated with diff on the done edge. ovf = (borrow into MSB bit) XOR (borrow out of MSB bit), i.e. two's-complement signed overflow of a-b. It holds like diff.
- Undefined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, reset 3 cycles, then start with a=0x5A, b=0x3C -> busy high 8 cycles, done pulse at cycle 9 after start edge, diff=0x1E, bout=0.
- a=0x00, b=0x01 -> diff=0xFF, bout=1; then a=0x80, b=0x80 -> diff=0x00, bout=0. diff/bout hold between operations.
- Start a=0x10, b=0x01; pulse start with a=0xFF, b=0x00 at busy cycle 3 -> ignored; result diff=0x0F, bout=0; exactly one done.
- Back-to-back: hold start=1 with new operands a=0x03, b=0x05 during the done cycle -> second op accepted immediately; second done 9 cycles later with diff=0xFE, bout=1.
- Reset mid-op: rst_n=0 at busy cycle 4 -> next cycle busy=0, diff=0, bout=0, and no done pulse follows. A later op a=0x22, b=0x11 gives diff=0x11.
- SERIAL_SUB_SIGNED_OVF_EN defined, WIDTH=8:
  - a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1;
  - a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1;
  - a=0x05, b=0x03 -> ovf=0.
  Also run WIDTH=1 exhaustive over all 4 (a,b) pairs, macro undefined.
